// File: rtl/instr_fetch_if.sv
// Fetch-side bus bundle: instruction ROM port, fetch control from the core,
// and the valid/ready instruction stream presented to decode.
interface instr_fetch_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready;

  // Fetch unit side
  modport master (
    output imem_addr,
    output inst_valid,
    output inst_data,
    output inst_pc,
    input  imem_data,
    input  fetch_en,
    input  redirect_valid,
    input  redirect_pc,
    input  inst_ready
  );

  // ROM / core / decode side
  modport slave (
    input  imem_addr,
    input  inst_valid,
    input  inst_data,
    input  inst_pc,
    output imem_data,
    output fetch_en,
    output redirect_valid,
    output redirect_pc,
    output inst_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch initiator: owns the PC, reads a combinational ROM and
// buffers {pc, word} pairs in a small circular prefetch queue for decode.
// Redirects flush the queue and restart fetch at the word-aligned target.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus
);
  localparam int             PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc;
  logic [31:0]      q_pc   [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;
  logic             push;
  logic             pop;
  logic [31:0]      redirect_word;

  assign bus.imem_addr  = fetch_pc;
  assign bus.inst_valid = (count != '0);
  assign bus.inst_data  = q_data[rd_ptr];
  assign bus.inst_pc    = q_pc[rd_ptr];

  // Handshake decode; a redirect suppresses the enqueue of the stale word
  always_comb begin
    redirect_word = bus.redirect_pc & ~32'h3;
    pop           = bus.inst_valid && bus.inst_ready;
    push          = bus.fetch_en && !bus.redirect_valid && ((count < FULL_CNT) || pop);
  end

  // PC, pointers and occupancy; reset beats redirect, redirect beats push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= redirect_word;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 32'd4;
        wr_ptr   <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage: cleared on reset so the head reads zero until first fill
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]   <= '0;
        q_data[i] <= '0;
      end
    end else if (push) begin
      q_pc[wr_ptr]   <= fetch_pc;
      q_data[wr_ptr] <= bus.imem_data;
    end
  end
endmodule
